argmax_seq_ctrl: RTL

//   Sequences one classification pass: reads NUM_CLASSES final-layer scores from score RAM, streams them

---
 rtl/argmax_seq_ctrl_if.sv | 28 ++
 rtl/argmax_seq_ctrl.sv | 134 +++++++++++++
 2 files changed

// File: rtl/argmax_seq_ctrl_if.sv
// rtl/argmax_seq_ctrl_if.sv - score RAM read, comparator feed and class result bundle
// master = sequencer, slave = RAM/comparator/consumer side.
interface argmax_seq_ctrl_if #(
  parameter int MEM_ADDR = 4,
  parameter int OUT_DW   = 4
);
  logic                mem_rd_en;
  logic [MEM_ADDR-1:0] mem_rd_addr;
  logic                cmp_start_sign;
  logic                cmp_read_en;
  logic [MEM_ADDR-1:0] cmp_address;
  logic [OUT_DW-1:0]   cmp_result;
  logic                cls_valid;
  logic                cls_ready;
  logic [OUT_DW-1:0]   cls_index;

  modport master (
    output mem_rd_en, mem_rd_addr, cmp_start_sign, cmp_read_en, cmp_address,
    output cls_valid, cls_index,
    input  cmp_result, cls_ready
  );

  modport slave (
    input  mem_rd_en, mem_rd_addr, cmp_start_sign, cmp_read_en, cmp_address,
    input  cls_valid, cls_index,
    output cmp_result, cls_ready
  );
endinterface

// File: rtl/argmax_seq_ctrl.sv
// rtl/argmax_seq_ctrl.sv - one argmax pass: clear comparator, stream scores, capture winner
// Read strobe/address pass through an RD_LAT delay line so the comparator sees them with the data.
module argmax_seq_ctrl #(
  parameter int MEM_ADDR    = 4,
  parameter int OUT_DW      = 4,
  parameter int NUM_CLASSES = 14,
  parameter int RD_LAT      = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  output logic               busy,
  output logic [7:0]         pass_cnt,
  argmax_seq_ctrl_if.master  bus
);

  localparam int DCW = (RD_LAT < 2) ? 1 : $clog2(RD_LAT);
  localparam logic [MEM_ADDR-1:0] LAST_ADDR  = MEM_ADDR'(NUM_CLASSES - 1);
  localparam logic [DCW-1:0]      DRAIN_LAST = DCW'(RD_LAT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_ISSUE,
    S_DRAIN,
    S_CAPTURE,
    S_OUTPUT
  } state_t;

  state_t              state, state_nx;
  logic [MEM_ADDR-1:0] addr_q, addr_nx;
  logic [DCW-1:0]      drain_q, drain_nx;
  logic                rd_en;
  logic [MEM_ADDR-1:0] rd_addr;
  logic                start_sign;
  logic                valid;
  logic                handshake;
  logic [RD_LAT-1:0]   en_pipe;
  logic [MEM_ADDR-1:0] addr_pipe [RD_LAT];
  logic [OUT_DW-1:0]   index_q;
  logic [7:0]          cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      addr_q  <= '0;
      drain_q <= '0;
    end else begin
      state   <= state_nx;
      addr_q  <= addr_nx;
      drain_q <= drain_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    addr_nx    = addr_q;
    drain_nx   = drain_q;
    rd_en      = 1'b0;
    rd_addr    = '0;
    start_sign = 1'b0;
    valid      = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) state_nx = S_CLEAR;
      end
      S_CLEAR: begin
        start_sign = 1'b1;
        addr_nx    = '0;
        state_nx   = S_ISSUE;
      end
      S_ISSUE: begin
        rd_en   = 1'b1;
        rd_addr = addr_q;
        // Counter parks on the last class so it never walks into unused RAM.
        if (addr_q == LAST_ADDR) begin
          drain_nx = '0;
          state_nx = S_DRAIN;
        end else begin
          addr_nx = addr_q + MEM_ADDR'(1);
        end
      end
      S_DRAIN: begin
        if (drain_q == DRAIN_LAST) state_nx = S_CAPTURE;
        else                       drain_nx = drain_q + DCW'(1);
      end
      S_CAPTURE: begin
        state_nx = S_OUTPUT;
      end
      S_OUTPUT: begin
        valid = 1'b1;
        if (bus.cls_ready) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      en_pipe <= '0;
      for (int i = 0; i < RD_LAT; i++) addr_pipe[i] <= '0;
    end else begin
      en_pipe[0]   <= rd_en;
      addr_pipe[0] <= rd_addr;
      for (int i = 1; i < RD_LAT; i++) begin
        en_pipe[i]   <= en_pipe[i-1];
        addr_pipe[i] <= addr_pipe[i-1];
      end
    end
  end

  assign handshake = valid & bus.cls_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      index_q <= '0;
      cnt_q   <= '0;
    end else begin
      if (state == S_CAPTURE) index_q <= bus.cmp_result;
      if (handshake)          cnt_q   <= cnt_q + 8'd1;
    end
  end

  assign busy               = (state != S_IDLE);
  assign pass_cnt           = cnt_q;
  assign bus.mem_rd_en      = rd_en;
  assign bus.mem_rd_addr    = rd_addr;
  assign bus.cmp_start_sign = start_sign;
  assign bus.cmp_read_en    = en_pipe[RD_LAT-1];
  assign bus.cmp_address    = addr_pipe[RD_LAT-1];
  assign bus.cls_valid      = valid;
  assign bus.cls_index      = index_q;

endmodule
